// File: rtl/ad7771_averager_if.sv
// ad7771_averager_if: sample-in / average-out bus between the sample reader, the averager and its consumer
interface ad7771_averager_if #(parameter int LOG2_N = 4);
  logic        enable_i;
  logic        sample_valid_i;
  logic [23:0] ch1_i;
  logic [23:0] ch2_i;
  logic        avg_valid_o;
  logic        avg_ready_i;
  logic [23:0] avg_ch1_o;
  logic [23:0] avg_ch2_o;
  logic [LOG2_N:0] count_o;
  logic        overrun_o;
  modport master (
    output enable_i, sample_valid_i, ch1_i, ch2_i, avg_ready_i,
    input  avg_valid_o, avg_ch1_o, avg_ch2_o, count_o, overrun_o
  );
  modport slave (
    input  enable_i, sample_valid_i, ch1_i, ch2_i, avg_ready_i,
    output avg_valid_o, avg_ch1_o, avg_ch2_o, count_o, overrun_o
  );
endinterface

// File: rtl/ad7771_averager.sv
// ad7771_averager: block-averages 2^LOG2_N two-channel samples into a valid/ready output register
module ad7771_averager #(
  parameter int LOG2_N = 4
) (
  input logic              clk_i,
  input logic              reset_ni,
  ad7771_averager_if.slave bus
);
  localparam int AW = 24 + LOG2_N;
  localparam logic [LOG2_N:0] LAST = (LOG2_N + 1)'((1 << LOG2_N) - 1);
  logic signed [AW-1:0] acc1_q, acc1_d, acc2_q, acc2_d, sum1, sum2;
  logic [LOG2_N:0] cnt_q, cnt_d;
  logic [23:0] avg1_q, avg1_d, avg2_q, avg2_d, res1, res2;
  logic valid_q, valid_d, ovr_q, ovr_d, accept, done, load;
  always_comb begin
    accept  = bus.enable_i && bus.sample_valid_i;
    sum1    = acc1_q + AW'(signed'(bus.ch1_i));
    sum2    = acc2_q + AW'(signed'(bus.ch2_i));
    // arithmetic shift floors toward minus infinity
    res1    = 24'(sum1 >>> LOG2_N);
    res2    = 24'(sum2 >>> LOG2_N);
    done    = accept && cnt_q == LAST;
    load    = done && (!valid_q || bus.avg_ready_i);
    acc1_d  = (!bus.enable_i || done) ? '0 : accept ? sum1 : acc1_q;
    acc2_d  = (!bus.enable_i || done) ? '0 : accept ? sum2 : acc2_q;
    cnt_d   = (!bus.enable_i || done) ? '0 : accept ? cnt_q + 1'b1 : cnt_q;
    avg1_d  = load ? res1 : avg1_q;
    avg2_d  = load ? res2 : avg2_q;
    valid_d = load ? 1'b1 : bus.avg_ready_i ? 1'b0 : valid_q;
    ovr_d   = ovr_q || (done && valid_q && !bus.avg_ready_i);
  end
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      acc1_q  <= '0;
      acc2_q  <= '0;
      cnt_q   <= '0;
      avg1_q  <= '0;
      avg2_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      acc1_q  <= acc1_d;
      acc2_q  <= acc2_d;
      cnt_q   <= cnt_d;
      avg1_q  <= avg1_d;
      avg2_q  <= avg2_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end
  assign bus.avg_valid_o = valid_q;
  assign bus.avg_ch1_o   = avg1_q;
  assign bus.avg_ch2_o   = avg2_q;
  assign bus.count_o     = cnt_q;
  assign bus.overrun_o   = ovr_q;
endmodule

// File: tb/tb_ad7771_averager.sv
// tb_ad7771_averager: checks LOG2_N = 0, 1, 2 averagers against a sample-list reference model
module tb_ad7771_averager;
  logic clk = 1'b0;
  logic rst_n, en, sv, rdy;
  logic [23:0] c1, c2;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic longint fdiv(input longint s, input longint n);
    longint q;
    q = s / n;
    if (s < 0 && s % n != 0) q = q - 1;
    return q;
  endfunction
  for (genvar g = 0; g < 3; g++) begin : u
    ad7771_averager_if #(.LOG2_N(g)) bus ();
    assign bus.enable_i       = en;
    assign bus.sample_valid_i = sv;
    assign bus.ch1_i          = c1;
    assign bus.ch2_i          = c2;
    assign bus.avg_ready_i    = rdy;
    ad7771_averager #(.LOG2_N(g)) dut (.clk_i(clk), .reset_ni(rst_n), .bus(bus));
    longint s1, s2;
    int len;
    logic [23:0] e1, e2;
    logic ev, eo;
    always @(posedge clk) begin
      longint q1, q2;
      bit done;
      done = 0;
      if (!rst_n) begin
        s1 = 0; s2 = 0; len = 0; e1 = '0; e2 = '0; ev = 0; eo = 0;
      end else begin
        if (!en) begin
          s1 = 0; s2 = 0; len = 0;
        end else if (sv) begin
          s1 += longint'($signed(c1));
          s2 += longint'($signed(c2));
          len++;
          if (len == (1 << g)) begin
            done = 1;
            q1 = fdiv(s1, 1 << g);
            q2 = fdiv(s2, 1 << g);
            s1 = 0; s2 = 0; len = 0;
          end
        end
        if (done && (!ev || rdy)) begin
          e1 = q1[23:0]; e2 = q2[23:0]; ev = 1;
        end else begin
          if (done) eo = 1;
          if (rdy) ev = 0;
        end
      end
    end
    always @(negedge clk) begin
      chk($sformatf("L%0d valid", g), bus.avg_valid_o, ev);
      chk($sformatf("L%0d ch1", g), bus.avg_ch1_o, e1);
      chk($sformatf("L%0d ch2", g), bus.avg_ch2_o, e2);
      chk($sformatf("L%0d count", g), bus.count_o, len);
      chk($sformatf("L%0d overrun", g), bus.overrun_o, eo);
    end
  end
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic drive(input logic [23:0] a, input logic [23:0] b);
    sv = 1'b1; c1 = a; c2 = b;
    idle(1);
    sv = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; en = 1'b1; sv = 1'b0; rdy = 1'b1; c1 = '0; c2 = '0;
    idle(2);
    chk("rst count", u[2].bus.count_o, 0);
    chk("rst valid", u[2].bus.avg_valid_o, 0);
    chk("rst ch1", u[2].bus.avg_ch1_o, 0);
    chk("rst ovr", u[2].bus.overrun_o, 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) drive(24'(4 * i), 24'(-4 * i));
    chk("basic valid", u[2].bus.avg_valid_o, 1);
    chk("basic ch1", u[2].bus.avg_ch1_o, 24'd10);
    chk("basic ch2", u[2].bus.avg_ch2_o, 24'hFFFFF6);
    idle(1);
    chk("hs drop", u[2].bus.avg_valid_o, 0);
    repeat (4) drive(24'h7FFFFF, 0);
    chk("max ch1", u[2].bus.avg_ch1_o, 24'h7FFFFF);
    repeat (4) drive(24'h800000, 0);
    chk("min ch1", u[2].bus.avg_ch1_o, 24'h800000);
    drive(24'hFFFFFF, 0);
    repeat (3) drive(0, 0);
    chk("floor ch1", u[2].bus.avg_ch1_o, 24'hFFFFFF);
    idle(1);
    rdy = 1'b0;
    repeat (4) drive(24'd20, 24'd1);
    chk("held valid", u[2].bus.avg_valid_o, 1);
    chk("held ch1", u[2].bus.avg_ch1_o, 24'd20);
    repeat (3) drive(24'd40, 24'd2);
    rdy = 1'b1;
    drive(24'd40, 24'd2);
    chk("b2b valid", u[2].bus.avg_valid_o, 1);
    chk("b2b ch1", u[2].bus.avg_ch1_o, 24'd40);
    chk("b2b ovr", u[2].bus.overrun_o, 0);
    rst_n = 1'b0; idle(1); rst_n = 1'b1;
    rdy = 1'b0;
    drive(24'd6, 0);
    drive(24'd8, 0);
    chk("stall first", u[1].bus.avg_ch1_o, 24'd7);
    drive(24'd100, 0);
    drive(24'd100, 0);
    chk("stall ovr", u[1].bus.overrun_o, 1);
    chk("stall keep", u[1].bus.avg_ch1_o, 24'd7);
    chk("stall valid", u[1].bus.avg_valid_o, 1);
    rdy = 1'b1;
    idle(1);
    chk("stall hs", u[1].bus.avg_valid_o, 0);
    chk("ovr sticky", u[1].bus.overrun_o, 1);
    drive(24'd5, 0);
    drive(24'd5, 0);
    rst_n = 1'b0; idle(1); rst_n = 1'b1;
    chk("midrst count", u[2].bus.count_o, 0);
    repeat (4) drive(24'd100, 0);
    chk("midrst ch1", u[2].bus.avg_ch1_o, 24'd100);
    drive(24'h123456, 24'hABCDEF);
    chk("n1 ch1", u[0].bus.avg_ch1_o, 24'h123456);
    chk("n1 ch2", u[0].bus.avg_ch2_o, 24'hABCDEF);
    drive(24'd1, 0);
    drive(24'd1, 0);
    en = 1'b0;
    idle(1);
    chk("dis count", u[2].bus.count_o, 0);
    drive(24'd999, 0);
    en = 1'b1;
    repeat (4) drive(24'd8, 0);
    chk("en ch1", u[2].bus.avg_ch1_o, 24'd8);
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(199) != 0);
      en    = ($urandom_range(99) < 95);
      sv    = $urandom_range(1);
      rdy   = ($urandom_range(99) < 70);
      c1    = ($urandom_range(7) == 0) ? ($urandom_range(1) ? 24'h7FFFFF : 24'h800000) : 24'($urandom);
      c2    = 24'($urandom);
      idle(1);
    end
    rst_n = 1'b1; sv = 1'b0;
    idle(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
